// File: rtl/uv_mul_ctrl.sv
// Issue/return controller for the pipelined multiplier: decodes M-extension multiplies,
// tracks destination tags through the fixed multiplier latency and buffers results for writeback.
module uv_mul_ctrl #(
    parameter int MUL_DW     = 32,
    parameter int PIPE_STAGE = 3,
    parameter int TAG_W      = 5,
    parameter int BUF_DEPTH  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [1:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [MUL_DW-1:0] in_opa,
    input  logic [MUL_DW-1:0] in_opb,
    output logic              mul_req_vld,
    output logic              mul_req_sgn,
    output logic              mul_req_mix,
    output logic              mul_req_low,
    output logic [MUL_DW-1:0] mul_req_opa,
    output logic [MUL_DW-1:0] mul_req_opb,
    input  logic              mul_rsp_vld,
    input  logic [MUL_DW-1:0] mul_rsp_res,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [TAG_W-1:0]  out_tag,
    output logic [MUL_DW-1:0] out_res,
    output logic              busy,
    output logic              err
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + PIPE_STAGE + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [PIPE_STAGE-1:0] pipeVld_q, pipeVld_d;
    logic [PIPE_STAGE-1:0] pipeLive_q, pipeLive_d;
    logic [TAG_W-1:0]      pipeTag_q [PIPE_STAGE];
    logic [TAG_W-1:0]      pipeTag_d [PIPE_STAGE];

    logic [CNT_W-1:0]      liveCnt_q, liveCnt_d;
    logic [CNT_W-1:0]      fifoCnt_q, fifoCnt_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [TAG_W-1:0]      fifoTag_q [BUF_DEPTH];
    logic [MUL_DW-1:0]     fifoRes_q [BUF_DEPTH];
    logic                  err_q, err_d;

    logic                  accept;
    logic                  lastVld;
    logic                  lastLive;
    logic                  retire;
    logic                  push;
    logic                  pop;
    logic [SUM_W-1:0]      creditSum;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits cover both in-flight and buffered results, so a response always finds FIFO space.
    assign creditSum = SUM_W'(liveCnt_q) + SUM_W'(fifoCnt_q);
    assign in_rdy    = !flush && (creditSum < SUM_W'(BUF_DEPTH));
    assign accept    = in_vld & in_rdy;

    assign lastVld   = pipeVld_q[PIPE_STAGE-1];
    assign lastLive  = pipeLive_q[PIPE_STAGE-1];
    assign retire    = lastVld & lastLive;
    assign push      = mul_rsp_vld & retire;
    assign pop       = out_vld & out_rdy;

    always_comb begin
        mul_req_vld = accept;
        mul_req_low = accept & (in_op == 2'b00);
        mul_req_sgn = accept & (in_op == 2'b01);
        mul_req_mix = accept & (in_op == 2'b10);
        mul_req_opa = in_opa;
        mul_req_opb = in_opb;
    end

    // Squashed entries keep their vld bit so response/tag alignment is still checked.
    always_comb begin
        pipeVld_d     = '0;
        pipeLive_d    = '0;
        for (int i = 0; i < PIPE_STAGE; i++) pipeTag_d[i] = '0;
        pipeVld_d[0]  = accept;
        pipeLive_d[0] = accept;
        pipeTag_d[0]  = in_tag;
        for (int i = 1; i < PIPE_STAGE; i++) begin
            pipeVld_d[i]  = pipeVld_q[i-1];
            pipeLive_d[i] = pipeLive_q[i-1];
            pipeTag_d[i]  = pipeTag_q[i-1];
        end
        if (flush) pipeLive_d = '0;
    end

    always_comb begin
        liveCnt_d = liveCnt_q + CNT_W'(accept) - CNT_W'(retire);
        fifoCnt_d = fifoCnt_q + CNT_W'(push) - CNT_W'(pop);
        wrPtr_d   = push ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d   = pop  ? nextPtr(rdPtr_q) : rdPtr_q;
        err_d     = err_q | (mul_rsp_vld != lastVld);
        if (flush) begin
            liveCnt_d = '0;
            fifoCnt_d = '0;
            wrPtr_d   = '0;
            rdPtr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipeVld_q  <= '0;
            pipeLive_q <= '0;
            for (int i = 0; i < PIPE_STAGE; i++) pipeTag_q[i] <= '0;
            liveCnt_q  <= '0;
            fifoCnt_q  <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            pipeVld_q  <= pipeVld_d;
            pipeLive_q <= pipeLive_d;
            for (int i = 0; i < PIPE_STAGE; i++) pipeTag_q[i] <= pipeTag_d[i];
            liveCnt_q  <= liveCnt_d;
            fifoCnt_q  <= fifoCnt_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fifoTag_q[i] <= '0;
                fifoRes_q[i] <= '0;
            end
        end else if (push && !flush) begin
            fifoTag_q[wrPtr_q] <= pipeTag_q[PIPE_STAGE-1];
            fifoRes_q[wrPtr_q] <= mul_rsp_res;
        end
    end

    assign out_vld = (fifoCnt_q != '0);
    assign out_tag = fifoTag_q[rdPtr_q];
    assign out_res = fifoRes_q[rdPtr_q];
    assign busy    = (liveCnt_q != '0) || (fifoCnt_q != '0);
    assign err     = err_q;

endmodule

// File: tb/tb_uv_mul_ctrl.sv
// Directed bench for uv_mul_ctrl, with a behavioural fixed-latency multiplier on the
// request/response side and hand-computed expected results.
module tb_uv_mul_ctrl;

    localparam int MUL_DW     = 32;
    localparam int PIPE_STAGE = 3;
    localparam int TAG_W      = 5;
    localparam int BUF_DEPTH  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_vld;
    logic              in_rdy;
    logic [1:0]        in_op;
    logic [TAG_W-1:0]  in_tag;
    logic [MUL_DW-1:0] in_opa;
    logic [MUL_DW-1:0] in_opb;
    logic              mul_req_vld;
    logic              mul_req_sgn;
    logic              mul_req_mix;
    logic              mul_req_low;
    logic [MUL_DW-1:0] mul_req_opa;
    logic [MUL_DW-1:0] mul_req_opb;
    logic              mul_rsp_vld;
    logic [MUL_DW-1:0] mul_rsp_res;
    logic              out_vld;
    logic              out_rdy;
    logic [TAG_W-1:0]  out_tag;
    logic [MUL_DW-1:0] out_res;
    logic              busy;
    logic              err;

    logic              injectRsp;
    logic              modelVld [PIPE_STAGE];
    logic [MUL_DW-1:0] modelRes [PIPE_STAGE];

    int compareCount  = 0;
    int mismatchCount = 0;

    uv_mul_ctrl #(
        .MUL_DW(MUL_DW), .PIPE_STAGE(PIPE_STAGE), .TAG_W(TAG_W), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_op(in_op), .in_tag(in_tag),
        .in_opa(in_opa), .in_opb(in_opb),
        .mul_req_vld(mul_req_vld), .mul_req_sgn(mul_req_sgn), .mul_req_mix(mul_req_mix),
        .mul_req_low(mul_req_low), .mul_req_opa(mul_req_opa), .mul_req_opb(mul_req_opb),
        .mul_rsp_vld(mul_rsp_vld), .mul_rsp_res(mul_rsp_res),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_tag(out_tag), .out_res(out_res),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mulModel(input logic sgn, input logic mix, input logic low,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] ea, eb, pr;
        ea = (sgn | mix) ? {{34{a[31]}}, a} : {34'b0, a};
        eb = sgn ? {{34{b[31]}}, b} : {34'b0, b};
        pr = ea * eb;
        return low ? pr[31:0] : pr[63:32];
    endfunction

    // Behavioural multiplier sharing rst_n with the controller.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGE; i++) begin
                modelVld[i] <= 1'b0;
                modelRes[i] <= '0;
            end
        end else begin
            modelVld[0] <= mul_req_vld;
            modelRes[0] <= mulModel(mul_req_sgn, mul_req_mix, mul_req_low, mul_req_opa, mul_req_opb);
            for (int i = 1; i < PIPE_STAGE; i++) begin
                modelVld[i] <= modelVld[i-1];
                modelRes[i] <= modelRes[i-1];
            end
        end
    end

    assign mul_rsp_vld = modelVld[PIPE_STAGE-1] | injectRsp;
    assign mul_rsp_res = modelRes[PIPE_STAGE-1];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic vld, input logic [1:0] op, input logic [TAG_W-1:0] tag,
                                 input logic [31:0] a, input logic [31:0] b);
        in_vld = vld;
        in_op  = op;
        in_tag = tag;
        in_opa = a;
        in_opb = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] hiRes [3];
        logic        hiSgn [3];
        logic        hiMix [3];
        int          seen;
        int          rdyLow;
        int          j;

        hiRes = '{32'h4000_0000, 32'hC000_0000, 32'h4000_0000};
        hiSgn = '{1'b1, 1'b0, 1'b0};
        hiMix = '{1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; flush = 1'b0; out_rdy = 1'b0; injectRsp = 1'b0;
        applyStimulus(0, 2'b00, '0, '0, '0);
        #3;
        checkOutput("rst_in_rdy", in_rdy, 1);
        checkOutput("rst_req", {mul_req_vld, mul_req_sgn, mul_req_mix, mul_req_low}, 0);
        checkOutput("rst_out", {out_vld, out_tag, out_res}, 0);
        checkOutput("rst_busy_err", {busy, err}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] single MUL");
        out_rdy = 1'b1;
        applyStimulus(1, 2'b00, 5'd4, 32'h0000_0007, 32'hFFFF_FFFD);
        checkOutput("mul_req", {mul_req_vld, mul_req_sgn, mul_req_mix, mul_req_low}, 4'b1001);
        checkOutput("mul_opa", mul_req_opa, 32'h0000_0007);
        tick();
        applyStimulus(0, 2'b00, '0, '0, '0);
        tick(); tick();
        checkOutput("mul_early", out_vld, 0);
        tick();
        checkOutput("mul_vld", out_vld, 1);
        checkOutput("mul_tag", out_tag, 4);
        checkOutput("mul_res", out_res, 32'hFFFF_FFEB);
        checkOutput("mul_busy", busy, 1);
        tick();
        checkOutput("mul_drain", {out_vld, busy}, 0);

        $display("[TB] high variants");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 2'(i + 1), 5'(i + 1), 32'h8000_0000, 32'h8000_0000);
            checkOutput("hi_sgn", mul_req_sgn, hiSgn[i]);
            checkOutput("hi_mix", mul_req_mix, hiMix[i]);
            checkOutput("hi_low", {mul_req_vld, mul_req_low}, 2'b10);
            tick();
        end
        applyStimulus(0, 2'b00, '0, '0, '0);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("hi_out", {out_vld, out_tag, out_res}, {1'b1, 5'(i + 1), hiRes[i]});
            tick();
        end

        $display("[TB] backpressure");
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 2'b00, 5'(10 + i), 32'(i + 1), 32'd2);
            checkOutput("bp_rdy", in_rdy, 1);
            tick();
        end
        applyStimulus(1, 2'b00, 5'd15, 32'd6, 32'd2);
        checkOutput("bp_rdy_low", in_rdy, 0);
        tick(); tick(); tick();
        checkOutput("bp_full_rdy", in_rdy, 0);
        out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checkOutput("bp_out", {out_vld, out_tag, out_res}, {1'b1, 5'(10 + k), 32'(2 * (k + 1))});
            if (k == 1) checkOutput("bp_rdy_back", in_rdy, 1);
            tick();
            if (k == 1) applyStimulus(0, 2'b00, '0, '0, '0);
        end
        checkOutput("bp_drain", {out_vld, busy}, 0);

        $display("[TB] streaming");
        j = 0;
        rdyLow = 0;
        for (int c = 0; c < 60; c++) begin
            if (c < 50) applyStimulus(1, 2'b00, 5'(c), 32'(c + 3), 32'd5);
            else        applyStimulus(0, 2'b00, '0, '0, '0);
            if (c < 50 && !in_rdy) rdyLow++;
            if (out_vld) begin
                checkOutput("stream_res", {out_tag, out_res}, {5'(j), 32'((j + 3) * 5)});
                j++;
            end
            tick();
        end
        checkOutput("stream_cnt", j, 50);
        checkOutput("stream_rdy_low", rdyLow, 0);

        $display("[TB] flush");
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 2'b00, 5'(20 + i), 32'(i + 1), 32'd3);
            tick();
        end
        applyStimulus(0, 2'b00, '0, '0, '0);
        checkOutput("fl_pre", {out_vld, busy}, 2'b11);
        flush = 1'b1;
        #1;
        checkOutput("fl_rdy", in_rdy, 0);
        tick();
        flush = 1'b0;
        checkOutput("fl_post", {out_vld, busy, err}, 0);
        out_rdy = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_vld) seen++;
            tick();
        end
        checkOutput("fl_dropped", seen, 0);
        checkOutput("fl_err", err, 0);
        applyStimulus(1, 2'b00, 5'd25, 32'd9, 32'd9);
        tick();
        applyStimulus(0, 2'b00, '0, '0, '0);
        tick(); tick(); tick();
        checkOutput("fl_after", {out_vld, out_tag, out_res}, {1'b1, 5'd25, 32'd81});
        tick(); tick();

        $display("[TB] stray response");
        checkOutput("inj_pre", err, 0);
        injectRsp = 1'b1;
        tick();
        injectRsp = 1'b0;
        checkOutput("inj_err", err, 1);
        tick(); tick(); tick();
        checkOutput("inj_sticky", err, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("inj_reset", {err, busy}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
